// File: rtl/dram_bridge.sv
// Load/store bridge between the core LSU and the word-addressed, byte-enabled data RAM.
// Handles one access at a time: range/alignment check, lane steering, and a programmable wait before the RAM access.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | mem_a driven; cnt counts down, access cycle when cnt==0
// RESP  | response held until resp_ready
module dram_bridge #(
    parameter int ADDR_BITS = 20,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [31:0]          req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-1:0] mem_a,
    output logic [3:0]           mem_we,
    output logic [31:0]          mem_d,
    input  logic [31:0]          mem_spo
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        req_bad;
    logic        access;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign req_bad = (req_size == 2'd3)
                  || (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                  || ((req_addr >> (ADDR_BITS + 2)) != 32'd0);

    assign access = (state == ST_WAIT) && (cnt == 4'd0);

    // Write strobes exist only in the access cycle, so an async reset kills them immediately.
    always_comb begin
        mem_we = 4'b0000;
        mem_d  = 32'd0;
        if (access && wr_q) begin
            case (size_q)
                2'd0: begin
                    mem_d  = {4{wdata_q[7:0]}};
                    mem_we = 4'b0001 << lane_q;
                end
                2'd1: begin
                    mem_d  = {2{wdata_q[15:0]}};
                    mem_we = lane_q[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    mem_d  = wdata_q;
                    mem_we = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte = 8'(mem_spo >> {lane_q, 3'b000});
        ld_half = lane_q[1] ? mem_spo[31:16] : mem_spo[15:0];
        case (size_q)
            2'd0:    ld_fmt = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_fmt = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_fmt = mem_spo;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_a      <= '0;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_wr;
                        signed_q  <= req_signed;
                        size_q    <= req_size;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (req_bad) begin
                            state      <= ST_RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LATENCY);
                            mem_a <= req_addr[ADDR_BITS+1:2];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wr_q ? 32'd0 : ld_fmt;
                    end
                end
                ST_RESP: begin
                    // Error responses enter RESP with valid low so they still surface one edge after acceptance.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_bridge.sv
// Randomized bench for dram_bridge: a byte-level memory model predicts every cycle's handshake, strobes and response.
// A second instance with zero wait latency gets a short directed run.
`timescale 1ns/1ps
module tb_dram_bridge;
    localparam int AB  = 20;
    localparam int LAT = 2;
    localparam logic [31:0] BYTE_RANGE = 32'd1 << (AB + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, req_ready, req_wr = 1'b0, req_signed = 1'b0;
    logic [31:0]   req_addr = 32'd0, req_wdata = 32'd0;
    logic [1:0]    req_size = 2'd0;
    logic          resp_valid, resp_ready = 1'b1, resp_err;
    logic [31:0]   resp_rdata, mem_d, mem_spo;
    logic [AB-1:0] mem_a;
    logic [3:0]    mem_we;

    logic          req_valid0 = 1'b0, req_ready0, req_wr0 = 1'b0, req_signed0 = 1'b0;
    logic [31:0]   req_addr0 = 32'd0, req_wdata0 = 32'd0;
    logic [1:0]    req_size0 = 2'd2;
    logic          resp_valid0, resp_ready0 = 1'b1, resp_err0;
    logic [31:0]   resp_rdata0, mem_d0, mem_spo0;
    logic [AB-1:0] mem_a0;
    logic [3:0]    mem_we0;

    dram_bridge #(.ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo)
    );

    dram_bridge #(.ADDR_BITS(AB), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr0), .req_addr(req_addr0),
        .req_size(req_size0), .req_signed(req_signed0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .mem_a(mem_a0), .mem_we(mem_we0), .mem_d(mem_d0), .mem_spo(mem_spo0)
    );

    // RAMs seen by the DUTs (asynchronous read, byte-enabled write)
    logic [31:0] ram  [0:4095];
    logic [31:0] ram0 [0:15];
    assign mem_spo  = ram[mem_a[11:0]];
    assign mem_spo0 = ram0[mem_a0[3:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) if (|mem_we)  ram[mem_a[11:0]]  <= merge(ram[mem_a[11:0]], mem_d, mem_we);
    always @(posedge clk) if (|mem_we0) ram0[mem_a0[3:0]] <= merge(ram0[mem_a0[3:0]], mem_d0, mem_we0);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event within bound, required one", name);
    endtask

    // Reference model: byte memory plus transaction bookkeeping in edges since acceptance.
    logic [7:0]  mbytes [0:16383];
    bit          busy = 0, ready_m = 0, acc_next = 0, hs_next = 0, hi_prev = 0, rv_m = 0;
    int          k = 0, lat_e = 0, nb = 0;
    bit          bad_e = 0, wr_e = 0;
    logic [31:0] rd_e = 0, d_e = 0, st_addr = 0, st_wd = 0;
    logic [3:0]  we_e = 0;
    logic [AB-1:0] a_e = '0;
    bit          pend_wr = 0, pend_sgn = 0;
    logic [1:0]  pend_size = 0;
    logic [31:0] pend_addr = 0, pend_wd = 0;
    bit          got_rv = 0;
    int          obs_lat = 0, obs_we_cyc = 0;
    logic [31:0] obs_rdata = 0;
    logic        obs_err = 0;
    logic [3:0]  obs_we = 0;
    logic [AB-1:0] obs_a = '0;

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit sgn);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[14'(addr + 32'(i))]) << (8 * i));
        if (sgn && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            busy = 0; ready_m = 0; acc_next = 0; hs_next = 0; hi_prev = 0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
            check("rst_resp_err", 32'(resp_err), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_a", 32'(mem_a), 32'd0);
            check("rst_mem_d", mem_d, 32'd0);
        end else begin
            if (hi_prev) begin
                if (acc_next) begin
                    busy = 1; ready_m = 0; k = 0;
                    got_rv = 0; obs_we = 0; obs_we_cyc = 0; obs_a = '0;
                    nb = 1 << pend_size;
                    bad_e = (pend_size == 2'd3) || (pend_addr >= BYTE_RANGE) || ((pend_addr % 32'(nb)) != 32'd0);
                    lat_e = bad_e ? 1 : LAT + 1;
                    wr_e  = pend_wr;
                    rd_e  = (bad_e || pend_wr) ? 32'd0 : model_load(pend_addr, nb, pend_sgn);
                    we_e  = 4'd0;
                    d_e   = 32'd0;
                    if (!bad_e && pend_wr) begin
                        we_e = 4'(((1 << nb) - 1) << (pend_addr & 32'd3));
                        for (int l = 0; l < 4; l++) d_e[8*l +: 8] = 8'(pend_wd >> (8 * (l % nb)));
                    end
                    a_e = AB'(pend_addr >> 2);
                    st_addr = pend_addr;
                    st_wd   = pend_wd;
                end else if (busy) begin
                    if (hs_next) begin
                        busy = 0; ready_m = 1;
                    end else begin
                        k++;
                        if (!bad_e && wr_e && k == LAT + 1)
                            for (int i = 0; i < nb; i++) mbytes[14'(st_addr + 32'(i))] = 8'(st_wd >> (8 * i));
                    end
                end else if (!ready_m) begin
                    ready_m = 1;
                end
            end
            rv_m = busy && (k >= lat_e);
            check("req_ready", 32'(req_ready), 32'(ready_m));
            check("resp_valid", 32'(resp_valid), 32'(rv_m));
            if (rv_m) begin
                check("resp_rdata", resp_rdata, rd_e);
                check("resp_err", 32'(resp_err), 32'(bad_e));
            end
            if (busy && !bad_e && wr_e && k == LAT) begin
                check("mem_we", 32'(mem_we), 32'(we_e));
                check("mem_d", mem_d, d_e);
            end else begin
                check("mem_we_idle", 32'(mem_we), 32'd0);
            end
            if (busy && !bad_e && k <= LAT) check("mem_a", 32'(mem_a), 32'(a_e));
            if (mem_we != 4'd0) begin
                obs_we = obs_we | mem_we; obs_we_cyc++; obs_a = mem_a;
            end
            if (busy && resp_valid && !got_rv) begin
                got_rv = 1; obs_lat = k; obs_rdata = resp_rdata; obs_err = resp_err;
            end
            acc_next  = req_valid && ready_m;
            pend_wr   = req_wr;  pend_sgn = req_signed; pend_size = req_size;
            pend_addr = req_addr; pend_wd = req_wdata;
            hs_next   = rv_m && resp_ready;
            hi_prev   = 1;
        end
    end

    int rr_mode = 0;   // 0: always ready, 1: random, 2: held low
    initial forever begin
        @(posedge clk); #1;
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = 1'b0;
        endcase
    end

    task automatic send_req(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                            input bit sgn, input logic [31:0] wd);
        @(posedge clk); #1;
        req_wr = wr; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wd; req_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(posedge clk);
            if (acc_next) break;
            if (n > 50) begin timeout("accept"); break; end
        end
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wr = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        for (int n = 0; ; n++) begin
            @(posedge clk);
            if (hs_next) break;
            if (n > 200) begin timeout("response"); break; end
        end
    endtask

    task automatic run(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input bit sgn, input logic [31:0] wd);
        send_req(wr, addr, size, sgn, wd);
        wait_done();
    endtask

    task automatic lat0_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd, output logic [3:0] we_seen);
        lat = -1; rd = 32'd0; we_seen = 4'd0;
        @(posedge clk); #1;
        req_wr0 = wr; req_addr0 = addr; req_wdata0 = wd; req_size0 = 2'd2; req_valid0 = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (req_ready0) break;
            if (n > 20) begin timeout("lat0_accept"); break; end
        end
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            we_seen = we_seen | mem_we0;
            if (mem_we0 != 4'd0) check("lat0_mem_a", 32'(mem_a0), addr >> 2);
            if (resp_valid0) begin lat = n; rd = resp_rdata0; break; end
            if (n > 20) begin timeout("lat0_response"); break; end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] w_before;
        int          l0_lat;
        logic [31:0] l0_rd;
        logic [3:0]  l0_we;
        int          mism;
        logic [1:0]  sz;
        logic [31:0] ad;

        for (int w = 0; w < 4096; w++) begin
            ram[w] = $urandom;
            for (int b = 0; b < 4; b++) mbytes[4*w + b] = ram[w][8*b +: 8];
        end
        for (int w = 0; w < 16; w++) ram0[w] = 32'd0;

        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // word store then load
        run(1, 32'h100, 2'd2, 0, 32'hDEADBEEF);
        check("st_word_we", 32'(obs_we), 32'hF);
        check("st_word_we_cycles", 32'(obs_we_cyc), 32'd1);
        check("st_word_mem_a", 32'(obs_a), 32'h40);
        check("st_word_lat", 32'(obs_lat), 32'd3);
        run(0, 32'h100, 2'd2, 0, 32'd0);
        check("ld_word_rdata", obs_rdata, 32'hDEADBEEF);
        check("ld_word_err", 32'(obs_err), 32'd0);
        check("ld_word_lat", 32'(obs_lat), 32'd3);

        // byte lanes
        run(1, 32'h200, 2'd2, 0, 32'h11223344);
        run(1, 32'h203, 2'd0, 0, 32'h00000080);
        check("st_byte_we", 32'(obs_we), 32'h8);
        run(0, 32'h200, 2'd2, 0, 32'd0);
        check("ld_after_byte", obs_rdata, 32'h80223344);
        run(0, 32'h203, 2'd0, 1, 32'd0);
        check("model_pin_sbyte", rd_e, 32'hFFFFFF80);
        check("ld_sbyte", obs_rdata, 32'hFFFFFF80);
        run(0, 32'h203, 2'd0, 0, 32'd0);
        check("ld_ubyte", obs_rdata, 32'h00000080);

        // half
        run(0, 32'h202, 2'd1, 1, 32'd0);
        check("ld_shalf", obs_rdata, 32'hFFFF8022);
        run(1, 32'h201, 2'd1, 0, 32'h0000ABCD);
        check("mis_half_err", 32'(obs_err), 32'd1);
        check("mis_half_rdata", obs_rdata, 32'd0);
        check("mis_half_lat", 32'(obs_lat), 32'd1);
        check("mis_half_we", 32'(obs_we_cyc), 32'd0);

        // range and size
        run(0, 32'h0040_0000, 2'd2, 0, 32'd0);
        check("range_err", 32'(obs_err), 32'd1);
        run(1, 32'h0, 2'd3, 0, 32'hFFFFFFFF);
        check("size3_err", 32'(obs_err), 32'd1);
        check("size3_we", 32'(obs_we_cyc), 32'd0);

        // backpressure
        rr_mode = 2;
        send_req(0, 32'h100, 2'd2, 0, 32'd0);
        for (int n = 0; n < 20 && !got_rv; n++) @(posedge clk);
        repeat (5) @(posedge clk);
        rr_mode = 0;
        wait_done();
        check("bp_rdata", obs_rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("bp_ready_after", 32'(req_ready), 32'd1);

        // reset during WAIT of a store
        w_before = ram[4];
        send_req(1, 32'h10, 2'd2, 0, 32'h12345678);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_ram", ram[4], w_before);

        // randomized traffic
        rr_mode = 1;
        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                ad = (32'($urandom_range(1, 1023)) << 22) | ($urandom & 32'h003F_FFFF);
            else begin
                ad = 32'($urandom_range(0, 16383));
                if (sz != 2'd3 && $urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            end
            run(1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rr_mode = 0;
        repeat (3) @(posedge clk);

        mism = 0;
        for (int w = 0; w < 4096; w++)
            if (ram[w] !== {mbytes[4*w+3], mbytes[4*w+2], mbytes[4*w+1], mbytes[4*w]}) mism++;
        check("ram_final_mismatches", 32'(mism), 32'd0);

        // zero-latency instance
        lat0_txn(1, 32'h8, 32'hCAFEF00D, l0_lat, l0_rd, l0_we);
        check("lat0_st_lat", 32'(l0_lat), 32'd1);
        check("lat0_st_we", 32'(l0_we), 32'hF);
        check("lat0_st_rdata", l0_rd, 32'd0);
        lat0_txn(0, 32'h8, 32'd0, l0_lat, l0_rd, l0_we);
        check("lat0_ld_lat", 32'(l0_lat), 32'd1);
        check("lat0_ld_rdata", l0_rd, 32'hCAFEF00D);
        check("lat0_ld_we", 32'(l0_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule
